// File: rtl/job_seq_pkg.sv
// job_seq_pkg: sequencer state encoding and fail counter width shared by the job sequencer files.
package job_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RETRY = 2'd2, FAILED = 2'd3} state_t;
  localparam int FAIL_CNT_W = 8;
endpackage

// File: rtl/job_seq_fifo.sv
// job_seq_fifo: power-of-two input job FIFO with registered occupancy and head-of-queue output.
module job_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign full_o  = r_cnt == (AW+1)'(DEPTH);
  assign empty_o = r_cnt == '0;
  assign head_o  = r_mem[r_rd];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr] <= data_i;
endmodule

// File: rtl/job_sequencer.sv
// job_sequencer: queues jobs and hands them to a worker with retry/fail tracking.
// Define JOB_SEQ_TIMEOUT_EN to add the worker response timeout.
module job_sequencer
  import job_seq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DW        = 8,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  input  logic [DW-1:0]         req_data_i,
  output logic                  req_ready_o,
  output logic                  job_valid_o,
  output logic [DW-1:0]         job_data_o,
  input  logic                  job_ack_i,
  input  logic                  job_err_i,
  input  logic                  clr_i,
  output state_t                state_o,
  output logic [FAIL_CNT_W-1:0] fail_cnt_o
);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  state_t                r_state, w_state_nxt;
  logic [DW-1:0]         r_job, w_head;
  logic [RW-1:0]         r_retry;
  logic [FAIL_CNT_W-1:0] r_fail_cnt;
  logic                  w_full, w_empty, w_push, w_pop, w_timeout, w_fault;
  assign req_ready_o = !w_full;
  assign w_push      = req_valid_i && req_ready_o;
  assign w_pop       = r_state == IDLE && !w_empty;
  assign job_valid_o = r_state == BUSY;
  assign job_data_o  = r_job;
  assign state_o     = r_state;
  assign fail_cnt_o  = r_fail_cnt;
  job_seq_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (w_push),
    .data_i (req_data_i),
    .pop_i  (w_pop),
    .full_o (w_full),
    .empty_o(w_empty),
    .head_o (w_head)
  );
`ifdef JOB_SEQ_TIMEOUT_EN
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] r_timer;
  // timer restarts on every BUSY entry, including re-entry after RETRY
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_timer <= '0;
    else r_timer <= r_state == BUSY ? r_timer + 1'b1 : '0;
  assign w_timeout = r_state == BUSY && r_timer == TW'(TIMEOUT - 1);
`else
  assign w_timeout = 1'b0;
`endif
  assign w_fault = job_err_i || w_timeout;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   w_state_nxt = w_empty ? IDLE : BUSY;
      BUSY:   w_state_nxt = job_ack_i ? IDLE : !w_fault ? BUSY :
                            32'(r_retry) < MAX_RETRY ? RETRY : FAILED;
      RETRY:  w_state_nxt = BUSY;
      FAILED: w_state_nxt = clr_i ? IDLE : FAILED;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_job      <= '0;
      r_retry    <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_job <= w_head;
      if (r_state == RETRY) r_retry <= r_retry + 1'b1;
      else if (w_state_nxt == IDLE) r_retry <= '0;
      if (r_state == BUSY && w_state_nxt == FAILED && r_fail_cnt != '1)
        r_fail_cnt <= r_fail_cnt + 1'b1;
    end
endmodule
